// File: rtl/io_responder.sv
// io_responder: memory-mapped LED, switch, timer and UART-TX registers on the IO bus.
// Define IO_UART_EN to build the UART TX FIFO and serializer; otherwise UTXD is ignored and USTAT reads empty.
module io_responder #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_ce_i,
  input  logic        io_we_i,
  input  logic [31:0] io_addr_i,
  input  logic [31:0] io_data_i,
  output logic [31:0] io_data_o,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic        timer_irq_o,
  output logic        uart_tx_o,
  output logic [1:0]  dbg_tx_state_o
);
  localparam logic [31:0] A_LED    = 32'hFFFF_0004;
  localparam logic [31:0] A_SW     = 32'hFFFF_0008;
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_000C;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0010;
  localparam logic [31:0] A_TSTAT  = 32'hFFFF_0014;
  localparam logic [31:0] A_UTXD   = 32'hFFFF_0018;
  localparam logic [31:0] A_USTAT  = 32'hFFFF_001C;

  // Bus handshake: io_ce_i is a one-cycle strobe with no ready/stall; reads are
  // combinational in that cycle and writes commit on the rising edge that ends it.
  logic        w_wr, w_rd;
  logic        w_wr_led, w_wr_tcount, w_wr_tcmp, w_wr_tstat;
  logic [31:0] w_ustat;

  logic [15:0] r_led, r_sw_meta, r_sw_sync;
  logic [31:0] r_tcount, r_tcmp;
  logic        r_match;

  assign w_wr        = io_ce_i & io_we_i;
  assign w_rd        = io_ce_i & ~io_we_i;
  assign w_wr_led    = w_wr & (io_addr_i == A_LED);
  assign w_wr_tcount = w_wr & (io_addr_i == A_TCOUNT);
  assign w_wr_tcmp   = w_wr & (io_addr_i == A_TCMP);
  assign w_wr_tstat  = w_wr & (io_addr_i == A_TSTAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led     <= 16'h0;
      r_sw_meta <= 16'h0;
      r_sw_sync <= 16'h0;
      r_tcount  <= 32'h0;
      r_tcmp    <= 32'hFFFF_FFFF;
      r_match   <= 1'b0;
    end else begin
      r_sw_meta <= sw_i;
      r_sw_sync <= r_sw_meta;
      if (w_wr_led) r_led <= io_data_i[15:0];
      r_tcount <= w_wr_tcount ? io_data_i : r_tcount + 32'd1;
      if (w_wr_tcmp) r_tcmp <= io_data_i;
      // A compare hit wins over a same-cycle W1C clear.
      r_match <= (r_tcount == r_tcmp) | (r_match & ~(w_wr_tstat & io_data_i[0]));
    end
  end

  assign led_o       = r_led;
  assign timer_irq_o = r_match;

`ifdef IO_UART_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  tx_state_t     r_state, w_state_nxt;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_data;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          w_full, w_empty, w_push, w_pop, w_baud_end, w_tx;

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_push     = w_wr & (io_addr_i == A_UTXD) & ~w_full;
  assign w_baud_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE:  if (!w_empty) begin
                 w_pop       = 1'b1;
                 w_state_nxt = S_START;
               end
      S_START: begin
                 w_tx = 1'b0;
                 if (w_baud_end) w_state_nxt = S_DATA;
               end
      S_DATA:  begin
                 w_tx = r_data[r_bit];
                 if (w_baud_end && (r_bit == 3'd7)) w_state_nxt = S_STOP;
               end
      S_STOP:  if (w_baud_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= io_data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= 8'h0;
      r_baud  <= '0;
      r_bit   <= 3'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_data <= r_fifo[r_rptr];
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_baud <= ((r_state == S_IDLE) || w_baud_end) ? '0 : r_baud + BW'(1);
      if (r_state != S_DATA)  r_bit <= 3'd0;
      else if (w_baud_end)    r_bit <= r_bit + 3'd1;
    end
  end

  assign uart_tx_o      = w_tx;
  assign dbg_tx_state_o = r_state;
  assign w_ustat        = {29'h0, (r_state != S_IDLE), w_empty, w_full};
`else
  assign uart_tx_o      = 1'b1;
  assign dbg_tx_state_o = 2'b00;
  assign w_ustat        = 32'h0000_0002;
`endif

  always_comb begin
    io_data_o = 32'h0;
    if (w_rd && !rst) begin
      case (io_addr_i)
        A_LED:    io_data_o = {16'h0, r_led};
        A_SW:     io_data_o = {16'h0, r_sw_sync};
        A_TCOUNT: io_data_o = r_tcount;
        A_TCMP:   io_data_o = r_tcmp;
        A_TSTAT:  io_data_o = {31'h0, r_match};
        A_USTAT:  io_data_o = w_ustat;
        default:  io_data_o = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_io_responder.sv
// Testbench for io_responder: register-level reference model, randomized bus traffic,
// and a UART line decoder feeding an expected-byte scoreboard.
module tb_io_responder;
  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam int HALF  = BAUD / 2;
  localparam logic [31:0] A_LED    = 32'hFFFF_0004;
  localparam logic [31:0] A_SW     = 32'hFFFF_0008;
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_000C;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0010;
  localparam logic [31:0] A_TSTAT  = 32'hFFFF_0014;
  localparam logic [31:0] A_UTXD   = 32'hFFFF_0018;
  localparam logic [31:0] A_USTAT  = 32'hFFFF_001C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_ce = 1'b0, io_we = 1'b0;
  logic [31:0] io_addr = 32'h0, io_wdata = 32'h0, io_rdata;
  logic [15:0] sw = 16'h0, led;
  logic        irq, tx;
  logic [1:0]  dbg_state;

  io_responder #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .io_ce_i(io_ce), .io_we_i(io_we), .io_addr_i(io_addr),
    .io_data_i(io_wdata), .io_data_o(io_rdata), .sw_i(sw), .led_o(led),
    .timer_irq_o(irq), .uart_tx_o(tx), .dbg_tx_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / checker ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  int          n_frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (register semantics) ----------------
  logic [15:0] m_led   = 16'h0;
  logic [31:0] m_tcount = 32'h0;
  logic [31:0] m_tcmp  = 32'hFFFF_FFFF;
  bit          m_match = 1'b0;
  logic [15:0] m_swq[$];
  bit          chk_ustat = 1'b1;
  logic [31:0] last_rd;
  logic        last_tx, last_irq;

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    case (addr)
      A_LED:    return {16'h0, m_led};
      A_SW:     return {16'h0, m_swq[0]};
      A_TCOUNT: return m_tcount;
      A_TCMP:   return m_tcmp;
      A_TSTAT:  return {31'h0, m_match};
      A_USTAT:  return 32'h0000_0002;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input bit ce, input bit we, input logic [31:0] addr, input logic [31:0] data);
    bit wr, nxt_match;
    if (rst) begin
      m_led = 16'h0; m_tcount = 32'h0; m_tcmp = 32'hFFFF_FFFF; m_match = 1'b0;
      m_swq = '{16'h0, 16'h0};
    end else begin
      wr = ce && we;
      nxt_match = (m_tcount == m_tcmp) || (m_match && !(wr && addr == A_TSTAT && data[0]));
      m_tcount  = (wr && addr == A_TCOUNT) ? data : m_tcount + 32'd1;
      if (wr && addr == A_TCMP) m_tcmp = data;
      if (wr && addr == A_LED)  m_led  = data[15:0];
      m_match = nxt_match;
      m_swq.push_back(sw);
      void'(m_swq.pop_front());
    end
  endtask

  // ---------------- driver: one bus cycle ----------------
  task automatic cycle(input bit ce, input bit we, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp_rd;
    @(negedge clk);
    io_ce = ce; io_we = we; io_addr = addr; io_wdata = data;
    #1;
    last_rd  = io_rdata;
    last_tx  = tx;
    last_irq = irq;
    exp_rd = (ce && !we && !rst) ? model_read(addr) : 32'h0;
    if (!(ce && !we && addr == A_USTAT && !chk_ustat))
      check($sformatf("rd@%08h", addr), io_rdata, exp_rd);
    check("led_o", {16'h0, led}, {16'h0, m_led});
    check("timer_irq_o", {31'h0, irq}, {31'h0, m_match});
    @(posedge clk);
    model_edge(ce, we, addr, data);
    #1;
  endtask

  // ---------------- UART line decoder ----------------
  logic [9:0] mon_bits;
  bit         mon_abort;
  initial begin : uart_mon
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_abort = 1'b0;
        mon_bits  = 10'h0;
        for (int c = 0; c <= 9*BAUD + HALF; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) mon_abort = 1'b1;
          if (c % BAUD == HALF) mon_bits[c / BAUD] = tx;
        end
        if (!mon_abort) begin
          n_frames++;
          check("frame_start_stop", {30'h0, mon_bits[9], mon_bits[0]}, 32'h2);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_extra: got byte 0x%02h, expected no frame", mon_bits[8:1]);
          end else begin
            check("frame_data", {24'h0, mon_bits[8:1]}, {24'h0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] addrs [10];
  logic [31:0] r_addr, r_data, tval;
  logic [7:0]  bytes6 [6];
  logic [9:0]  pat;
  bit          r_ce, r_we, done;

  initial begin
    m_swq = '{16'h0, 16'h0};
    addrs = '{A_LED, A_SW, A_TCOUNT, A_TCMP, A_TSTAT, A_UTXD, A_USTAT,
              32'hFFFF_0000, 32'hFFFF_0020, 32'h0000_0008};
    repeat (3) @(posedge clk);
    #1;
    // read while in reset returns 0
    cycle(1, 0, A_LED, 32'h0);
    rst = 1'b0;
    cycle(1, 0, A_TCMP, 32'h0);   check("rst_tcmp", last_rd, 32'hFFFF_FFFF);
    cycle(1, 0, A_TSTAT, 32'h0);  check("rst_tstat", last_rd, 32'h0);
    cycle(1, 0, A_USTAT, 32'h0);  check("rst_ustat", last_rd, 32'h2);
    check("rst_tx", {31'h0, last_tx}, 32'h1);
    check("rst_led", {16'h0, led}, 32'h0);

    // LED write/read
    cycle(1, 1, A_LED, 32'h0000_A5A5);
    cycle(1, 0, A_LED, 32'h0);
    check("led_a5a5", {16'h0, led}, 32'h0000_A5A5);
    check("rd_led", last_rd, 32'h0000_A5A5);

    // switch synchronizer latency
    sw = 16'h1234;
    cycle(1, 0, A_SW, 32'h0);  check("sw_lag0", last_rd, 32'h0);
    cycle(1, 0, A_SW, 32'h0);  check("sw_lag1", last_rd, 32'h0);
    cycle(1, 0, A_SW, 32'h0);  check("sw_sync", last_rd, 32'h0000_1234);

    // timer wrap, match and W1C
    cycle(1, 1, A_TCOUNT, 32'hFFFF_FFFE);
    cycle(1, 1, A_TCMP, 32'h0000_0001);
    cycle(1, 0, A_TCOUNT, 32'h0);  check("tc_ffff", last_rd, 32'hFFFF_FFFF);
    cycle(1, 0, A_TCOUNT, 32'h0);  check("tc_wrap0", last_rd, 32'h0);
    cycle(1, 0, A_TCOUNT, 32'h0);  check("tc_one", last_rd, 32'h1);
    check("irq_not_yet", {31'h0, last_irq}, 32'h0);
    cycle(1, 0, A_TSTAT, 32'h0);   check("tstat_match", last_rd, 32'h1);
    check("irq_rise", {31'h0, last_irq}, 32'h1);
    cycle(1, 1, A_TSTAT, 32'h1);
    cycle(1, 0, A_TSTAT, 32'h0);   check("tstat_clr", last_rd, 32'h0);
    tval = m_tcount + 32'd1;
    cycle(1, 1, A_TCMP, tval);
    cycle(1, 1, A_TSTAT, 32'h1);   // compare hits in this same cycle
    cycle(1, 0, A_TSTAT, 32'h0);   check("tstat_set_wins", last_rd, 32'h1);
    cycle(1, 1, A_TSTAT, 32'h1);
    cycle(1, 0, A_TSTAT, 32'h0);   check("tstat_clr2", last_rd, 32'h0);

    // randomized register traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
      r_addr = addrs[$urandom_range(0, 9)];
      r_we   = 1'($urandom_range(0, 1));
      r_ce   = ($urandom_range(0, 3) != 0);
      r_data = $urandom;
      if (r_addr == A_TCMP && $urandom_range(0, 1) == 1)
        r_data = m_tcount + 32'($urandom_range(1, 5));
`ifdef IO_UART_EN
      if (r_addr == A_UTXD) r_we = 1'b0;
`endif
      cycle(r_ce, r_we, r_addr, r_data);
    end

`ifdef IO_UART_EN
    chk_ustat = 1'b0;
    // single frame 0x55, exact line timing
    cycle(1, 1, A_UTXD, 32'h0000_0055);
    exp_q.push_back(8'h55);
    cycle(1, 0, A_USTAT, 32'h0);  check("ustat_pending", last_rd, 32'h0);
    pat = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10*BAUD; i++) begin
      cycle(1, 0, A_USTAT, 32'h0);
      check($sformatf("tx55_c%0d", i), {31'h0, last_tx}, {31'h0, pat[i / BAUD]});
      check("busy_55", {31'h0, last_rd[2]}, 32'h1);
    end
    cycle(1, 0, A_USTAT, 32'h0);  check("ustat_done", last_rd, 32'h2);
    check("frames_55", n_frames, 32'd1);

    // six back-to-back pushes: one popped, four queued, one dropped
    for (int i = 0; i < 6; i++) bytes6[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, A_UTXD, {24'h0, bytes6[i]});
      if (i < 5) exp_q.push_back(bytes6[i]);
    end
    cycle(1, 0, A_USTAT, 32'h0);  check("ustat_full", last_rd, 32'h5);
    done = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      cycle(1, 0, A_USTAT, 32'h0);
      done = (last_rd == 32'h2) && (exp_q.size() == 0);
    end
    check("drain_done", {31'h0, done}, 32'h1);
    check("frames_6", n_frames, 32'd6);
    repeat (50) cycle(0, 0, 32'h0, 32'h0);
    check("frames_quiet", n_frames, 32'd6);

    // reset during data bit 3 aborts frame and discards FIFO
    cycle(1, 1, A_UTXD, 32'h0000_00F7);
    cycle(1, 1, A_UTXD, 32'h0000_003C);
    exp_q.push_back(8'hF7);
    repeat (4*BAUD + 1) cycle(1, 0, A_USTAT, 32'h0);
    rst = 1'b1;
    cycle(1, 0, A_LED, 32'h0);
    check("tx_bit3", {31'h0, last_tx}, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    cycle(1, 0, A_USTAT, 32'h0);
    check("abort_tx", {31'h0, last_tx}, 32'h1);
    check("abort_ustat", last_rd, 32'h2);
    repeat (100) cycle(0, 0, 32'h0, 32'h0);
    check("abort_no_frames", n_frames, 32'd6);
    chk_ustat = 1'b1;
`else
    // UART absent: pushes ignored, line idle, USTAT reads empty
    for (int i = 0; i < 6; i++) cycle(1, 1, A_UTXD, $urandom);
    for (int i = 0; i < 50; i++) begin
      cycle(1, 0, A_USTAT, 32'h0);
      check("noua_ustat", last_rd, 32'h2);
      check("noua_tx", {31'h0, last_tx}, 32'h1);
    end
    check("noua_frames", n_frames, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
